cdc_hs_rx: RTL and testbench

//  Destination-domain receiver for toggle-handshake CDC transfers. Sits directly downstream of a
//  cdc_2ff_sync instance, which delivers the synchronized request toggle. Detects each toggle,

---
 rtl/cdc_pkg.sv | 16 +
 rtl/cdc_tgl_edge.sv | 30 +++
 rtl/cdc_hs_rx.sv | 115 +++++++++++
 tb/tb_cdc_hs_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC receiver and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdc_pkg;

  // Settle counter width; supports settle windows of 0..15 cycles.
  localparam int SETTLE_W = 4;

  // Receiver handshake states.
  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,
    HS_SETTLE = 2'd1,
    HS_VALID  = 2'd2
  } hs_state_e;

endpackage

// File: rtl/cdc_tgl_edge.sv
// Toggle edge detector: registers a synchronized toggle and flags any change.
// Latency: combinational edge_out in the cycle the toggle differs from its registered copy.
// Backpressure: none; every change is reported exactly once.
module cdc_tgl_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_in,
  output logic edge_out
);

  logic tgl_q;
  logic tgl_d;

  // Registered copy simply follows the input every cycle.
  always_comb begin
    tgl_d = tgl_in;
  end

  // Previous-value register; restarts at 0 with the shared reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgl_q <= 1'b0;
    end else begin
      tgl_q <= tgl_d;
    end
  end

  assign edge_out = tgl_in ^ tgl_q;

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination-side toggle-handshake receiver: detect toggle, settle, capture, present valid/ready.
// Latency: data_valid from SETTLE_CYCLES+1 cycles after the toggle edge is seen.
// Backpressure: word held until data_valid & data_ready, then ack_tgl flips once.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              ack_tgl,
  output logic              err,
  input  logic              err_clr
);

  // With no settle window the capture happens in the edge cycle itself.
  localparam bit                  NO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [SETTLE_W-1:0] CNT_LOAD  = NO_SETTLE ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] CNT_ONE   = SETTLE_W'(1);

  hs_state_e           state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                req_edge;
  logic                capture;
  logic                accept;
  logic                violation;

  cdc_tgl_edge u_req_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgl_in   (req_tgl),
    .edge_out (req_edge)
  );

  // State, counter, captured word, ack toggle and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HS_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Next-state: edge starts a transfer, settle counts down, acceptance returns to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (req_edge) begin
          if (NO_SETTLE) begin
            capture = 1'b1;
            state_d = HS_VALID;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = HS_SETTLE;
          end
        end
      end
      HS_SETTLE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = HS_VALID;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HS_VALID: begin
        if (data_ready) begin
          accept  = 1'b1;
          state_d = HS_IDLE;
        end
      end
      default: begin
        state_d = HS_IDLE;
      end
    endcase
  end

  // Datapath: capture once per transfer; an edge outside IDLE is dropped but flagged, set beats clear.
  always_comb begin
    data_d    = capture ? data_in : data_q;
    ack_d     = ack_q ^ accept;
    violation = req_edge && (state_q != HS_IDLE);
    err_d     = violation | (err_q & ~err_clr);
  end

  // Outputs come straight from state and registers.
  always_comb begin
    data_valid = (state_q == HS_VALID);
    data_out   = data_q;
    ack_tgl    = ack_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_cdc_hs_rx.sv
module tb_cdc_hs_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_tgl;
  logic        err_clr;
  logic        data_ready;
  logic [31:0] data_in;

  logic [31:0] dout1, dout0;
  logic        vld1, vld0, ack1, ack0, err1, err0;

  cdc_hs_rx #(.DATA_W(32), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .data_in(data_in),
    .data_out(dout1), .data_valid(vld1), .data_ready(data_ready),
    .ack_tgl(ack1), .err(err1), .err_clr(err_clr)
  );

  cdc_hs_rx #(.DATA_W(32), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .data_in(data_in),
    .data_out(dout0), .data_valid(vld0), .data_ready(data_ready),
    .ack_tgl(ack0), .err(err0), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          vcyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Flip the request; when a word is expected, queue it with its first-valid cycle per instance.
  task automatic send(logic [31:0] d, bit expect_word);
    data_in = d;
    req_tgl = ~req_tgl;
    if (expect_word) begin
      q1.push_back('{data: d, vcyc: cyc + 2});
      q0.push_back('{data: d, vcyc: cyc + 1});
    end
  endtask

  // Monitor for the SETTLE_CYCLES=1 instance.
  logic pv1 = 1'b0;
  logic ea1 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv1 = 1'b0;
      ea1 = 1'b0;
      q1.delete();
    end else begin
      chk("ack_s1", {31'd0, ack1}, {31'd0, ea1});
      if (vld1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_s1: data_valid=1 data_out=%h with no word expected", dout1);
        end else begin
          if (!pv1) chk("latency_s1", 32'(cyc), 32'(q1[0].vcyc));
          chk("data_s1", dout1, q1[0].data);
          if (data_ready) begin
            void'(q1.pop_front());
            ea1 = ~ea1;
          end
        end
      end
      pv1 = vld1;
    end
  end

  // Monitor for the SETTLE_CYCLES=0 instance.
  logic pv0 = 1'b0;
  logic ea0 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv0 = 1'b0;
      ea0 = 1'b0;
      q0.delete();
    end else begin
      chk("ack_s0", {31'd0, ack0}, {31'd0, ea0});
      if (vld0) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_s0: data_valid=1 data_out=%h with no word expected", dout0);
        end else begin
          if (!pv0) chk("latency_s0", 32'(cyc), 32'(q0[0].vcyc));
          chk("data_s0", dout0, q0[0].data);
          if (data_ready) begin
            void'(q0.pop_front());
            ea0 = ~ea0;
          end
        end
      end
      pv0 = vld0;
    end
  end

  logic [31:0] words [4];

  initial begin
    rst_n      = 1'b0;
    req_tgl    = 1'b0;
    err_clr    = 1'b0;
    data_ready = 1'b1;
    data_in    = 32'h0;
    words[0]   = 32'h0000_0011;
    words[1]   = 32'h2222_0022;
    words[2]   = 32'h3333_0033;
    words[3]   = 32'hFFFF_0044;

    // Reset values
    @(negedge clk);
    chk("rst_valid_s1", {31'd0, vld1}, 32'd0);
    chk("rst_ack_s1",   {31'd0, ack1}, 32'd0);
    chk("rst_err_s1",   {31'd0, err1}, 32'd0);
    chk("rst_dout_s1",  dout1, 32'd0);
    chk("rst_valid_s0", {31'd0, vld0}, 32'd0);
    chk("rst_ack_s0",   {31'd0, ack0}, 32'd0);
    chk("rst_err_s0",   {31'd0, err0}, 32'd0);
    chk("rst_dout_s0",  dout0, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Basic transfer with data_ready held high
    send(32'hA5A5_0001, 1'b1);
    step(3);
    @(negedge clk);
    chk("basic_ack_s1", {31'd0, ack1}, 32'd1);
    step(2);

    // Backpressure: ten cycles of data_ready=0, data_in changes after capture
    data_ready = 1'b0;
    send(32'h1234_5678, 1'b1);
    step(3);
    data_in = 32'hDEAD_BEEF;
    step(7);
    @(negedge clk);
    chk("bp_hold_ack_s1", {31'd0, ack1}, 32'd1);
    chk("bp_hold_vld_s1", {31'd0, vld1}, 32'd1);
    step(1);
    data_ready = 1'b1;
    step(3);
    @(negedge clk);
    chk("bp_ack_s1", {31'd0, ack1}, 32'd0);
    step(1);

    // Back-to-back: four words, each two cycles after the previous ack
    for (int i = 0; i < 4; i++) begin
      send(words[i], 1'b1);
      step(5);
    end
    @(negedge clk);
    chk("b2b_ack_s1", {31'd0, ack1}, 32'd0);
    chk("b2b_err_s1", {31'd0, err1}, 32'd0);
    chk("b2b_err_s0", {31'd0, err0}, 32'd0);
    step(1);

    // Protocol violation during VALID, clear, then clear coincident with a violation
    data_ready = 1'b0;
    send(32'hC0DE_0005, 1'b1);
    step(3);
    send(32'hBAD0_0001, 1'b0);
    step(1);
    @(negedge clk);
    chk("viol_err_s1", {31'd0, err1}, 32'd1);
    chk("viol_err_s0", {31'd0, err0}, 32'd1);
    step(1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err_s1", {31'd0, err1}, 32'd0);
    chk("clr_err_s0", {31'd0, err0}, 32'd0);
    step(1);
    send(32'hBAD0_0002, 1'b0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("setwins_err_s1", {31'd0, err1}, 32'd1);
    chk("setwins_err_s0", {31'd0, err0}, 32'd1);
    step(1);
    data_ready = 1'b1;
    step(3);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    step(1);

    // Reset while the S=1 instance is settling (S=0 instance already valid)
    data_ready = 1'b0;
    send(32'h6666_0001, 1'b1);
    step(1);
    rst_n   = 1'b0;
    req_tgl = 1'b0;
    #1;
    chk("rst_settle_vld_s1", {31'd0, vld1}, 32'd0);
    chk("rst_settle_vld_s0", {31'd0, vld0}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Reset while both instances are presenting a word
    send(32'h6666_0002, 1'b1);
    step(3);
    rst_n   = 1'b0;
    req_tgl = 1'b0;
    #1;
    chk("rst_valid_vld_s1", {31'd0, vld1}, 32'd0);
    chk("rst_valid_vld_s0", {31'd0, vld0}, 32'd0);
    chk("rst_valid_dout_s1", dout1, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Fresh transfer after reset completes normally
    data_ready = 1'b1;
    send(32'h7777_0003, 1'b1);
    step(5);
    @(negedge clk);
    chk("final_ack_s1", {31'd0, ack1}, 32'd1);
    chk("final_err_s1", {31'd0, err1}, 32'd0);
    chk("drained_s1", 32'(q1.size()), 32'd0);
    chk("drained_s0", 32'(q0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
